// File: rtl/dram_reader_pkg.sv
// Shared types and constants for the DRAM read master.
`timescale 1ns/1ps
package dram_reader_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ADDR,
    ST_DATA
  } state_t;

  localparam logic [1:0]  AXI_BURST_INCR  = 2'b01;
  localparam logic [1:0]  AXI_RESP_OKAY   = 2'b00;
  localparam logic [2:0]  AXI_SIZE_16B    = 3'b100;
  localparam int unsigned PAGE_BYTES      = 4096;
  localparam int unsigned DATA_WIDTH_BITS = 128;
  localparam int unsigned BEAT_BYTES      = DATA_WIDTH_BITS / 8;

endpackage

// File: rtl/dram_burst_splitter.sv
// Splits a request at the next 4 KB page: first-burst beats, remainder,
// and the start address of the following page.
`timescale 1ns/1ps
module dram_burst_splitter
  import dram_reader_pkg::*;
#(
  parameter int unsigned AXI_ADDR_WIDTH = 40
) (
  input  logic [AXI_ADDR_WIDTH-1:0] i_addr,
  input  logic [7:0]                i_len,
  output logic [7:0]                o_burst1,
  output logic [7:0]                o_rem,
  output logic [AXI_ADDR_WIDTH-1:0] o_next_addr
);

  localparam int unsigned PW = AXI_ADDR_WIDTH - 12;

  logic [12:0] w_page_left;
  logic [8:0]  w_first;

  assign w_page_left = 13'(PAGE_BYTES) - {1'b0, i_addr[11:0]};
  // Page-aligned start yields 256 beats, which never limits an 8-bit length.
  assign w_first     = 9'(w_page_left >> $clog2(BEAT_BYTES));
  assign o_burst1    = ({1'b0, i_len} < w_first) ? i_len : w_first[7:0];
  assign o_rem       = i_len - o_burst1;
  assign o_next_addr = {i_addr[AXI_ADDR_WIDTH-1:12] + PW'(1), 12'h000};

endmodule

// File: rtl/dram_reader.sv
// AXI4 read master for the display pipeline; INCR bursts split at 4 KB.
// Optional error status ports: define DRAM_READER_ERR_STATUS_EN.
`timescale 1ns/1ps
module dram_reader
  import dram_reader_pkg::*;
#(
  parameter int unsigned DRAM_ADDR_WIDTH = 39,
  parameter int unsigned DRAM_DATA_WIDTH = 128,
  parameter int unsigned AXI_ADDR_WIDTH  = 40
) (
  input  logic                       clk_pixel,
  input  logic                       dram_reader_reset_n,
  input  logic                       dram_reader_flush,
  input  logic [DRAM_ADDR_WIDTH-1:0] dram_read_addr,
  input  logic [7:0]                 dram_read_len,
  input  logic                       dram_read_en,
  output logic                       dram_read_busy,
  output logic [DRAM_DATA_WIDTH-1:0] dram_read_data,
  output logic                       dram_read_data_valid,
`ifdef DRAM_READER_ERR_STATUS_EN
  output logic                       dram_read_err,
  output logic [15:0]                dram_read_err_cnt,
`endif
  output logic [AXI_ADDR_WIDTH-1:0]  m_axi_araddr,
  output logic [7:0]                 m_axi_arlen,
  output logic [2:0]                 m_axi_arsize,
  output logic [1:0]                 m_axi_arburst,
  output logic                       m_axi_arvalid,
  input  logic                       m_axi_arready,
  input  logic [DRAM_DATA_WIDTH-1:0] m_axi_rdata,
  input  logic [1:0]                 m_axi_rresp,
  input  logic                       m_axi_rlast,
  input  logic                       m_axi_rvalid,
  output logic                       m_axi_rready
);

  state_t                     r_state, w_state_nxt;
  logic [AXI_ADDR_WIDTH-1:0]  r_araddr, r_next_addr, w_req_addr, w_split_next;
  logic [7:0]                 r_arlen, r_rem, r_beat_cnt, w_burst1, w_rem;
  logic                       r_drop, r_valid;
  logic [DRAM_DATA_WIDTH-1:0] r_data;
  logic                       w_accept, w_ar_hs, w_r_hs, w_last_beat;
  logic                       w_flush, w_drop, w_more;

  assign w_req_addr  = AXI_ADDR_WIDTH'(dram_read_addr) & ~AXI_ADDR_WIDTH'(BEAT_BYTES - 1);
  assign w_accept    = (r_state == ST_IDLE) & dram_read_en & (dram_read_len != 8'd0);
  assign w_ar_hs     = (r_state == ST_ADDR) & m_axi_arready;
  assign w_r_hs      = (r_state == ST_DATA) & m_axi_rvalid;
  assign w_last_beat = (r_beat_cnt == r_arlen);
  assign w_flush     = dram_reader_flush & (r_state != ST_IDLE);
  // Flush takes effect on the very beat it coincides with.
  assign w_drop      = r_drop | w_flush;
  assign w_more      = (r_rem != 8'd0) & ~w_drop;

  dram_burst_splitter #(
    .AXI_ADDR_WIDTH(AXI_ADDR_WIDTH)
  ) u_splitter (
    .i_addr     (w_req_addr),
    .i_len      (dram_read_len),
    .o_burst1   (w_burst1),
    .o_rem      (w_rem),
    .o_next_addr(w_split_next)
  );

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (w_accept) w_state_nxt = ST_ADDR;
      ST_ADDR: if (m_axi_arready) w_state_nxt = ST_DATA;
      ST_DATA: if (w_r_hs && w_last_beat) w_state_nxt = w_more ? ST_ADDR : ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_pixel or negedge dram_reader_reset_n) begin
    if (!dram_reader_reset_n) r_state <= ST_IDLE;
    else                      r_state <= w_state_nxt;
  end

  always_ff @(posedge clk_pixel or negedge dram_reader_reset_n) begin
    if (!dram_reader_reset_n) begin
      r_araddr    <= '0;
      r_next_addr <= '0;
      r_arlen     <= '0;
      r_rem       <= '0;
      r_beat_cnt  <= '0;
      r_drop      <= 1'b0;
      r_valid     <= 1'b0;
      r_data      <= '0;
    end else begin
      if (w_accept) begin
        r_araddr    <= w_req_addr;
        r_arlen     <= w_burst1 - 8'd1;
        r_rem       <= w_rem;
        r_next_addr <= w_split_next;
        r_drop      <= dram_reader_flush;
      end else begin
        if (w_flush) begin
          r_drop <= 1'b1;
          r_rem  <= '0;
        end
        if (w_ar_hs) r_beat_cnt <= '0;
        if (w_r_hs) begin
          r_beat_cnt <= r_beat_cnt + 8'd1;
          if (w_last_beat) begin
            if (w_more) begin
              r_araddr <= r_next_addr;
              r_arlen  <= r_rem - 8'd1;
              r_rem    <= '0;
            end else begin
              r_drop <= 1'b0;
            end
          end
        end
      end
      r_valid <= w_r_hs & ~w_drop;
      if (w_r_hs && !w_drop) r_data <= m_axi_rdata;
    end
  end

`ifdef DRAM_READER_ERR_STATUS_EN
  logic        r_err, w_bad;
  logic [15:0] r_err_cnt;

  assign w_bad = w_r_hs & ((m_axi_rresp != AXI_RESP_OKAY) | (m_axi_rlast != w_last_beat));

  always_ff @(posedge clk_pixel or negedge dram_reader_reset_n) begin
    if (!dram_reader_reset_n) begin
      r_err     <= 1'b0;
      r_err_cnt <= '0;
    end else if (w_bad) begin
      r_err <= 1'b1;
      if (r_err_cnt != 16'hFFFF) r_err_cnt <= r_err_cnt + 16'd1;
    end
  end

  assign dram_read_err     = r_err;
  assign dram_read_err_cnt = r_err_cnt;
`else
  logic w_unused;
  assign w_unused = ^{m_axi_rresp, m_axi_rlast};
`endif

  assign dram_read_busy       = (r_state != ST_IDLE) | dram_read_en;
  assign dram_read_data       = r_data;
  assign dram_read_data_valid = r_valid;
  assign m_axi_araddr         = r_araddr;
  assign m_axi_arlen          = r_arlen;
  assign m_axi_arsize         = AXI_SIZE_16B;
  assign m_axi_arburst        = AXI_BURST_INCR;
  assign m_axi_arvalid        = (r_state == ST_ADDR);
  assign m_axi_rready         = (r_state == ST_DATA);

endmodule
